load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
MEM-stage initiator that drives the byte-addressed, big-endian data memory on behalf of the RISC-V pipeline. It accepts one load/store request at a time over a valid/ready handshake and translates RISC-V funct3 into the memory's Size/SignExt/ReadWrite/Enable controls. Misaligned accesses are split into sequential byte accesses and reassembled. It returns one response per request, carrying load data or a fault flag.

Parameters:
MEM_BYTES, 512, size of the data memory in bytes; any byte address at or above MEM_BYTES faults
MISALIGN_SPLIT, 1, 1 = split misaligned H/W accesses into byte accesses; 0 = misaligned access faults

Ports:
clk  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept; high only in IDLE
req_store  in  1  1 = store, 0 = load
req_funct3  in  3  RISC-V funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores and faults
resp_fault  out  1  illegal funct3 or out-of-range/misaligned-disallowed access
mem_enable  out  1  memory Enable
mem_rw  out  1  memory ReadWrite (1 = write)
mem_signext  out  1  memory SignExt
mem_size  out  2  memory Size: 00 BYTE, 01 HALFWORD, 10 WORD
mem_address  out  32  memory Address
mem_datain  out  32  memory DataIn
mem_dataout  in  32  memory DataOut (combinational read)

Behaviour:
- Reset (async, immediate): state IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_fault=0; all mem_* outputs =0.
- All mem_* outputs come straight from flops. mem_address, mem_datain, mem_size, and mem_rw update on the same edge. mem_enable is high only in ACCESS/SPLIT, because the memory is level-sensitive.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE: on req_valid&req_ready, latch the request and decode it:
  - size = funct3[1:0]
  - n = 1, 2, or 4 bytes
  - illegal = load funct3 in {011, 110, 111}, or store funct3 > 010
  - range fault = addr+n-1 >= MEM_BYTES (32-bit compare; wrap past 0xFFFFFFFF also faults)
  - misaligned = (H and addr[0]) or (W and addr[1:0]!=0)
- Next state after IDLE:
  - Any fault (illegal, range, or misaligned with MISALIGN_SPLIT=0): go to RESP with fault=1. mem_enable never asserts.
  - Aligned access: go to ACCESS.
  - Misaligned access with MISALIGN_SPLIT=1: go to SPLIT with k=0.
- ACCESS, one cycle:
  - Drive enable=1, rw=store, size, address=addr, signext=~funct3[2] for loads (0 for stores), datain=wdata.
  - Load: capture mem_dataout, masked to the access width ({24'b0,byte} / {16'b0,half} / word), into the accumulator. Extension is done locally from funct3[2] when forming the response, so resp_rdata does not depend on the memory's SignExt behaviour.
  - Go to RESP.
- SPLIT, one cycle per byte, k = 0..n-1:
  - Drive enable=1, size=BYTE, signext=0, address=addr+k.
  - Store: datain[7:0] = wdata[8*(n-1-k)+7 -: 8], upper bits 0.
  - Load: acc = {acc[23:0], mem_dataout[7:0]}. This places addr as the MSB (big-endian).
  - After k=n-1, go to RESP.
- RESP, one cycle:
  - resp_valid=1, mem_enable=0.
  - Load: resp_rdata = acc extended to 32 bits, sign-extended when funct3[2]=0.
  - Store or fault: resp_rdata=0.
  - Go to IDLE.
- Latency from the acceptance edge:
  - Aligned access: resp_valid high 2 cycles later.
  - Split access: n+1 cycles later.
  - Fault: 1 cycle later.
- Throughput: a new request can be accepted in the cycle after RESP. There is no backpressure on the response.
- Reset mid-split-store: already-written bytes remain in memory. No response is issued.

Decomposition:
- Package lsu_pkg holds: Size codes BYTE/HALFWORD/WORD, funct3 constants, the state enum, and a size-to-byte-count function.
- Optional sub-module load_extend: combinational; takes acc, size, and unsigned flag, outputs the 32-bit result.

Test Plan:
- Aligned LW at 0x10, memory bytes 11 22 33 44: mem_enable high 1 cycle with size=10, rw=0, then resp_rdata=0x11223344, resp_valid 2 cycles after accept.
- Byte 0x80 at 0x20: LB returns 0xFFFFFF80. LBU returns 0x00000080. LHU at 0x20 with bytes 80 01 returns 0x00008001.
- SW 0xA1B2C3D4 at 0x03 (MISALIGN_SPLIT=1): 4 consecutive byte writes to addresses 3/4/5/6 with data A1/B2/C3/D4, resp 5 cycles after accept. A following LW at 0x03 returns 0xA1B2C3D4.
- LW at 0x1FE, or funct3=011: resp_fault=1 one cycle after accept, resp_rdata=0, mem_enable never high.
- MISALIGN_SPLIT=0, LH at 0x05: fault. The same request with MISALIGN_SPLIT=1: 2 byte reads, halfword assembled big-endian.
- Reset asserted during byte 2 of a split SW: all outputs 0 immediately, no resp_valid. After release, req_ready=1 and back-to-back requests with req_valid held are accepted in IDLE only.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: memory size codes, funct3 encodings,
// FSM states and byte-lane helpers.
package lsu_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_SPLIT,
      ST_RESP
   } lsu_state_e;

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: size_bytes = 3'd1;
         SIZE_HALF: size_bytes = 3'd2;
         default:   size_bytes = 3'd4;
      endcase
   endfunction

   // Byte k of an n-byte store in big-endian order (k=0 is the most significant byte).
   function automatic logic [7:0] be_byte(input logic [XLEN-1:0] w, input logic [2:0] n,
                                          input logic [1:0] k);
      logic [2:0] idx;
      idx = n - 3'd1 - {1'b0, k};
      be_byte = w[{idx[1:0], 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/load_extend.sv
// Extends a right-justified load accumulator to 32 bits by access width.
module load_extend
   import lsu_pkg::*;
(
   input  logic [XLEN-1:0] acc_i,
   input  logic [1:0]      size_i,
   input  logic            unsigned_i,
   output logic [XLEN-1:0] data_o
);

   always_comb begin
      data_o = acc_i;
      case (size_i)
         SIZE_BYTE: data_o = unsigned_i ? {24'h0, acc_i[7:0]}  : {{24{acc_i[7]}}, acc_i[7:0]};
         SIZE_HALF: data_o = unsigned_i ? {16'h0, acc_i[15:0]} : {{16{acc_i[15]}}, acc_i[15:0]};
         default:   data_o = acc_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store initiator for a big-endian byte-addressed data memory;
// misaligned halfword/word accesses are optionally split into byte accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES      = 512,
   parameter bit          MISALIGN_SPLIT = 1'b1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_store,
   input  logic [2:0]      req_funct3,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            resp_valid,
   output logic [XLEN-1:0] resp_rdata,
   output logic            resp_fault,
   output logic            mem_enable,
   output logic            mem_rw,
   output logic            mem_signext,
   output logic [1:0]      mem_size,
   output logic [XLEN-1:0] mem_address,
   output logic [XLEN-1:0] mem_datain,
   input  logic [XLEN-1:0] mem_dataout
);

   lsu_state_e      state_q;
   logic            store_q, fault_q;
   logic [2:0]      funct3_q, n_q;
   logic [1:0]      k_q;
   logic [XLEN-1:0] addr_q, wdata_q, acc_q;

   logic            req_ready_q, resp_valid_q, resp_fault_q;
   logic [XLEN-1:0] resp_rdata_q;
   logic            mem_enable_q, mem_rw_q, mem_signext_q;
   logic [1:0]      mem_size_q;
   logic [XLEN-1:0] mem_address_q, mem_datain_q;

   assign req_ready   = req_ready_q;
   assign resp_valid  = resp_valid_q;
   assign resp_rdata  = resp_rdata_q;
   assign resp_fault  = resp_fault_q;
   assign mem_enable  = mem_enable_q;
   assign mem_rw      = mem_rw_q;
   assign mem_signext = mem_signext_q;
   assign mem_size    = mem_size_q;
   assign mem_address = mem_address_q;
   assign mem_datain  = mem_datain_q;

   // Request decode; the 33-bit end address catches wrap past 0xFFFFFFFF.
   logic [1:0]  dec_size;
   logic [2:0]  dec_n;
   logic [32:0] dec_end;
   logic        dec_illegal, dec_range, dec_misal, dec_fault;

   always_comb begin
      dec_size    = req_funct3[1:0];
      dec_n       = size_bytes(dec_size);
      dec_illegal = req_store ? !(req_funct3 inside {F3_SB, F3_SH, F3_SW})
                              : !(req_funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      dec_end     = {1'b0, req_addr} + 33'(dec_n) - 33'd1;
      dec_range   = dec_end >= 33'(MEM_BYTES);
      dec_misal   = ((dec_size == SIZE_HALF) && req_addr[0]) ||
                    ((dec_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
      dec_fault   = dec_illegal || dec_range || (dec_misal && !MISALIGN_SPLIT);
   end

   logic [XLEN-1:0] acc_masked, ext_data;
   logic [1:0]      k_nxt;
   logic            split_last;

   always_comb begin
      case (funct3_q[1:0])
         SIZE_BYTE: acc_masked = {24'h0, mem_dataout[7:0]};
         SIZE_HALF: acc_masked = {16'h0, mem_dataout[15:0]};
         default:   acc_masked = mem_dataout;
      endcase
      k_nxt      = k_q + 2'd1;
      split_last = (k_q == 2'(n_q - 3'd1));
   end

   load_extend u_load_extend (
      .acc_i      (acc_q),
      .size_i     (funct3_q[1:0]),
      .unsigned_i (funct3_q[2]),
      .data_o     (ext_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         store_q       <= 1'b0;
         fault_q       <= 1'b0;
         funct3_q      <= 3'b000;
         n_q           <= 3'd0;
         k_q           <= 2'd0;
         addr_q        <= '0;
         wdata_q       <= '0;
         acc_q         <= '0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_fault_q  <= 1'b0;
         resp_rdata_q  <= '0;
         mem_enable_q  <= 1'b0;
         mem_rw_q      <= 1'b0;
         mem_signext_q <= 1'b0;
         mem_size_q    <= 2'b00;
         mem_address_q <= '0;
         mem_datain_q  <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  store_q     <= req_store;
                  funct3_q    <= req_funct3;
                  addr_q      <= req_addr;
                  wdata_q     <= req_wdata;
                  n_q         <= dec_n;
                  k_q         <= 2'd0;
                  acc_q       <= '0;
                  fault_q     <= dec_fault;
                  req_ready_q <= 1'b0;
                  if (dec_fault) begin
                     state_q <= ST_RESP;
                  end else begin
                     mem_enable_q  <= 1'b1;
                     mem_rw_q      <= req_store;
                     mem_address_q <= req_addr;
                     if (dec_misal) begin
                        state_q       <= ST_SPLIT;
                        mem_size_q    <= SIZE_BYTE;
                        mem_signext_q <= 1'b0;
                        mem_datain_q  <= req_store ? {24'h0, be_byte(req_wdata, dec_n, 2'd0)} : '0;
                     end else begin
                        state_q       <= ST_ACCESS;
                        mem_size_q    <= dec_size;
                        mem_signext_q <= !req_store && !req_funct3[2];
                        mem_datain_q  <= req_wdata;
                     end
                  end
               end
            end
            ST_ACCESS: begin
               if (!store_q) acc_q <= acc_masked;
               mem_enable_q <= 1'b0;
               state_q      <= ST_RESP;
            end
            ST_SPLIT: begin
               // Shifting in from the bottom leaves the lowest address in the MSB.
               if (!store_q) acc_q <= {acc_q[23:0], mem_dataout[7:0]};
               if (split_last) begin
                  mem_enable_q <= 1'b0;
                  state_q      <= ST_RESP;
               end else begin
                  k_q           <= k_nxt;
                  mem_address_q <= addr_q + 32'(k_nxt);
                  mem_datain_q  <= store_q ? {24'h0, be_byte(wdata_q, n_q, k_nxt)} : '0;
               end
            end
            ST_RESP: begin
               resp_valid_q <= 1'b1;
               resp_fault_q <= fault_q;
               resp_rdata_q <= (store_q || fault_q) ? '0 : ext_data;
               req_ready_q  <= 1'b1;
               state_q      <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a big-endian byte memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_valid2;
   logic        req_store;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;

   logic        req_ready, resp_valid, resp_fault;
   logic [31:0] resp_rdata;
   logic        mem_enable, mem_rw, mem_signext;
   logic [1:0]  mem_size;
   logic [31:0] mem_address, mem_datain, mem_dout;

   logic        d2_req_ready, d2_resp_valid, d2_resp_fault;
   logic [31:0] d2_resp_rdata;
   logic        d2_mem_enable, d2_mem_rw, d2_mem_signext;
   logic [1:0]  d2_mem_size;
   logic [31:0] d2_mem_address, d2_mem_datain;
   logic [31:0] d2_dout = 32'h0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.MEM_BYTES(512), .MISALIGN_SPLIT(1'b1)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_fault(resp_fault), .mem_enable(mem_enable), .mem_rw(mem_rw),
      .mem_signext(mem_signext), .mem_size(mem_size), .mem_address(mem_address),
      .mem_datain(mem_datain), .mem_dataout(mem_dout));

   load_store_unit #(.MEM_BYTES(512), .MISALIGN_SPLIT(1'b0)) dut_nosplit (
      .clk(clk), .reset(reset), .req_valid(req_valid2), .req_ready(d2_req_ready),
      .req_store(req_store), .req_funct3(req_funct3), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(d2_resp_valid), .resp_rdata(d2_resp_rdata),
      .resp_fault(d2_resp_fault), .mem_enable(d2_mem_enable), .mem_rw(d2_mem_rw),
      .mem_signext(d2_mem_signext), .mem_size(d2_mem_size), .mem_address(d2_mem_address),
      .mem_datain(d2_mem_datain), .mem_dataout(d2_dout));

   // Memory model: combinational big-endian read, write on the clock while enabled.
   logic [7:0] mem [0:511];
   logic       init_mem;
   logic [8:0] ma0, ma1, ma2, ma3;
   logic [7:0] b0, b1, b2, b3;
   assign ma0 = mem_address[8:0];
   assign ma1 = ma0 + 9'd1;
   assign ma2 = ma0 + 9'd2;
   assign ma3 = ma0 + 9'd3;
   assign b0 = mem[ma0];
   assign b1 = mem[ma1];
   assign b2 = mem[ma2];
   assign b3 = mem[ma3];

   always_comb begin
      case (mem_size)
         2'b00:   mem_dout = mem_signext ? {{24{b0[7]}}, b0} : {24'h0, b0};
         2'b01:   mem_dout = mem_signext ? {{16{b0[7]}}, b0, b1} : {16'h0, b0, b1};
         default: mem_dout = {b0, b1, b2, b3};
      endcase
   end

   typedef struct {
      logic [31:0] a;
      logic [1:0]  sz;
      logic        rw;
      logic [31:0] d;
   } acc_t;
   acc_t log_q[$];
   int   en_cnt = 0;
   int   d2_en_cnt = 0;

   always @(posedge clk) begin
      if (init_mem) begin
         for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
         mem[9'h010] <= 8'h11; mem[9'h011] <= 8'h22;
         mem[9'h012] <= 8'h33; mem[9'h013] <= 8'h44;
         mem[9'h020] <= 8'h80; mem[9'h021] <= 8'h01;
      end else if (mem_enable) begin
         en_cnt <= en_cnt + 1;
         log_q.push_back('{a: mem_address, sz: mem_size, rw: mem_rw, d: mem_datain});
         if (mem_rw) begin
            case (mem_size)
               2'b00: mem[ma0] <= mem_datain[7:0];
               2'b01: begin mem[ma0] <= mem_datain[15:8]; mem[ma1] <= mem_datain[7:0]; end
               default: begin
                  mem[ma0] <= mem_datain[31:24]; mem[ma1] <= mem_datain[23:16];
                  mem[ma2] <= mem_datain[15:8];  mem[ma3] <= mem_datain[7:0];
               end
            endcase
         end
      end
      if (d2_mem_enable) d2_en_cnt <= d2_en_cnt + 1;
   end

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string name);
      chk(name, {req_ready, resp_valid, resp_fault, resp_rdata, mem_enable, mem_rw,
                 mem_signext, mem_size, mem_address, mem_datain},
          {1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0});
   endtask

   // Issue one request on the split-enabled unit; latency counts edges after acceptance.
   task automatic run(input string name, input logic st, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic flt, output int lat, output int en);
      int en0;
      @(negedge clk);
      chk({name, "_ready"}, 128'(req_ready), 128'(1));
      en0        = en_cnt;
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      rd  = resp_rdata;
      flt = resp_fault;
      en  = en_cnt - en0;
   endtask

   typedef struct {
      string       name;
      logic        st;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_rd;
      logic        exp_flt;
      int          exp_lat;
      int          exp_en;
   } vec_t;

   function automatic vec_t mk(string n, logic st, logic [2:0] f3, logic [31:0] a,
                               logic [31:0] wd, logic [31:0] r, logic f, int l, int e);
      vec_t v;
      v.name = n; v.st = st; v.f3 = f3; v.addr = a; v.wd = wd;
      v.exp_rd = r; v.exp_flt = f; v.exp_lat = l; v.exp_en = e;
      return v;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[$];
      logic [31:0] rd;
      logic        flt;
      int          lat, en, base, accepts, resps, w;
      logic [7:0]  sw_bytes [4];

      reset = 1'b1; init_mem = 1'b1;
      req_valid = 1'b0; req_valid2 = 1'b0;
      req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("reset_state");
      init_mem = 1'b0;
      reset    = 1'b0;

      // Aligned LW with memory-side controls checked.
      base = log_q.size();
      run("lw_10", 1'b0, 3'b010, 32'h10, 32'h0, rd, flt, lat, en);
      chk("lw_10_rdata", 128'(rd), 128'(32'h11223344));
      chk("lw_10_lat", 128'(lat), 128'(2));
      chk("lw_10_en", 128'(en), 128'(1));
      if (log_q.size() == base + 1)
         chk("lw_10_ctl", {log_q[base].sz, log_q[base].rw, log_q[base].a},
             {2'b10, 1'b0, 32'h10});
      else chk("lw_10_log", 128'(log_q.size() - base), 128'(1));

      // Misaligned SW split into four byte writes, big-endian order.
      sw_bytes[0] = 8'hA1; sw_bytes[1] = 8'hB2; sw_bytes[2] = 8'hC3; sw_bytes[3] = 8'hD4;
      base = log_q.size();
      run("sw_03", 1'b1, 3'b010, 32'h3, 32'hA1B2C3D4, rd, flt, lat, en);
      chk("sw_03_lat", 128'(lat), 128'(5));
      chk("sw_03_resp", {flt, rd}, {1'b0, 32'h0});
      chk("sw_03_nwr", 128'(log_q.size() - base), 128'(4));
      if (log_q.size() == base + 4)
         for (int k = 0; k < 4; k++)
            chk($sformatf("sw_03_byte%0d", k),
                {log_q[base+k].a, log_q[base+k].sz, log_q[base+k].rw, log_q[base+k].d},
                {32'(3 + k), 2'b00, 1'b1, {24'h0, sw_bytes[k]}});

      vecs.push_back(mk("lb_20",    0, 3'b000, 32'h20,  0, 32'hFFFFFF80, 0, 2, 1));
      vecs.push_back(mk("lbu_20",   0, 3'b100, 32'h20,  0, 32'h00000080, 0, 2, 1));
      vecs.push_back(mk("lhu_20",   0, 3'b101, 32'h20,  0, 32'h00008001, 0, 2, 1));
      vecs.push_back(mk("lh_20",    0, 3'b001, 32'h20,  0, 32'hFFFF8001, 0, 2, 1));
      vecs.push_back(mk("lw_03",    0, 3'b010, 32'h3,   0, 32'hA1B2C3D4, 0, 5, 4));
      vecs.push_back(mk("lh_05",    0, 3'b001, 32'h5,   0, 32'hFFFFC3D4, 0, 3, 2));
      vecs.push_back(mk("lhu_05",   0, 3'b101, 32'h5,   0, 32'h0000C3D4, 0, 3, 2));
      vecs.push_back(mk("lw_1fe",   0, 3'b010, 32'h1FE, 0, 32'h0,        1, 1, 0));
      vecs.push_back(mk("ld_f3_3",  0, 3'b011, 32'h0,   0, 32'h0,        1, 1, 0));
      vecs.push_back(mk("ld_f3_6",  0, 3'b110, 32'h0,   0, 32'h0,        1, 1, 0));
      vecs.push_back(mk("ld_f3_7",  0, 3'b111, 32'h0,   0, 32'h0,        1, 1, 0));
      vecs.push_back(mk("sb_1ff",   1, 3'b000, 32'h1FF, 32'h5A, 32'h0,   0, 2, 1));
      vecs.push_back(mk("lbu_1ff",  0, 3'b100, 32'h1FF, 0, 32'h0000005A, 0, 2, 1));
      vecs.push_back(mk("lw_1fc",   0, 3'b010, 32'h1FC, 0, 32'h0000005A, 0, 2, 1));
      vecs.push_back(mk("sh_1ff",   1, 3'b001, 32'h1FF, 32'h1234, 32'h0, 1, 1, 0));
      vecs.push_back(mk("st_f3_4",  1, 3'b100, 32'h40,  32'h1234, 32'h0, 1, 1, 0));
      vecs.push_back(mk("lw_wrap",  0, 3'b010, 32'hFFFFFFFE, 0, 32'h0,   1, 1, 0));
      vecs.push_back(mk("sh_40",    1, 3'b001, 32'h40,  32'h1234, 32'h0, 0, 2, 1));
      vecs.push_back(mk("lhu_40",   0, 3'b101, 32'h40,  0, 32'h00001234, 0, 2, 1));
      vecs.push_back(mk("lh_41",    0, 3'b001, 32'h41,  0, 32'h00003400, 0, 3, 2));

      foreach (vecs[i]) begin
         run(vecs[i].name, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wd, rd, flt, lat, en);
         chk({vecs[i].name, "_rdata"}, 128'(rd),  128'(vecs[i].exp_rd));
         chk({vecs[i].name, "_fault"}, 128'(flt), 128'(vecs[i].exp_flt));
         chk({vecs[i].name, "_lat"},   128'(lat), 128'(vecs[i].exp_lat));
         chk({vecs[i].name, "_en"},    128'(en),  128'(vecs[i].exp_en));
      end

      // Split disabled: misaligned LH faults one edge after acceptance.
      @(negedge clk);
      chk("nosplit_ready", 128'(d2_req_ready), 128'(1));
      req_store = 1'b0; req_funct3 = 3'b001; req_addr = 32'h5; req_valid2 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid2 = 1'b0;
      w = 0;
      while (!d2_resp_valid && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk("nosplit_lat", 128'(w), 128'(1));
      chk("nosplit_resp", {d2_resp_fault, d2_resp_rdata}, {1'b1, 32'h0});
      chk("nosplit_en", 128'(d2_en_cnt), 128'(0));

      // Reset while the third byte of a split SW is on the bus.
      @(negedge clk);
      req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h81; req_wdata = 32'h11223344;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_mid_bus", {mem_enable, mem_address, mem_datain}, {1'b1, 32'h83, 32'h33});
      reset = 1'b1;
      #1;
      chk_reset_outputs("rst_mid_outputs");
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk($sformatf("rst_no_resp%0d", c), 128'(resp_valid), 128'(0));
      end
      chk("rst_mem_kept", {mem[9'h081], mem[9'h082], mem[9'h083], mem[9'h084]},
          {8'h11, 8'h22, 8'h00, 8'h00});
      chk("rst_ready", 128'(req_ready), 128'(1));

      // Back-to-back LBU with req_valid held: one accept per three cycles.
      req_store = 1'b0; req_funct3 = 3'b100; req_addr = 32'h20; req_valid = 1'b1;
      accepts = 0; resps = 0;
      for (int c = 0; c < 12; c++) begin
         if (req_ready) accepts++;
         @(negedge clk);
         if (resp_valid) begin
            resps++;
            chk($sformatf("b2b_rdata%0d", resps), {resp_fault, resp_rdata}, {1'b0, 32'h80});
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 128'(accepts), 128'(4));
      chk("b2b_resps", 128'(resps), 128'(4));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
